// File: rtl/input_buffer_sequencer.sv
// ---------------------------------------------------------------------------
// input_buffer_sequencer
//
// Streams words from the activation buffer into the input mux register that
// feeds the PE array. Each 32-bit word is read once and then held for P mux
// phases, where P depends on the weight bitwidth:
//   00 -> 8-bit weights, P = 1
//   01 -> 4-bit weights, P = 2
//   10/11 -> 2-bit weights, P = 4
// The sequencer also drives the mux register's bitwidth select and its clear
// input. This keeps the mux phase counter aligned to word boundaries. It
// flags valid mux outputs and honours PE back-pressure only between words.
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   start             one-cycle run request, ignored unless idle
//   base_addr         first word address, sampled on an accepted start
//   num_words         words in the run, sampled on an accepted start
//   weight_bitwidth   bitwidth code, sampled on an accepted start
//   pe_ready          PE array can take a new word (word boundaries only)
//   buf_rd_en         buffer read strobe (data valid the following cycle)
//   buf_rd_addr       buffer read address
//   cfg_bitwidth      latched bitwidth, drives the mux bitwidth select
//   mux_clear         mux register reset; low only while a word is active
//   out_valid         mux register output holds valid data this cycle
//   out_last          final phase of the final word (with out_valid)
//   busy              run in progress
//   done              one-cycle pulse at run completion
// ---------------------------------------------------------------------------
module input_buffer_sequencer #(
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  num_words,
    input  logic [1:0]        weight_bitwidth,
    input  logic              pe_ready,
    output logic              buf_rd_en,
    output logic [ADDR_W-1:0] buf_rd_addr,
    output logic [1:0]        cfg_bitwidth,
    output logic              mux_clear,
    output logic              out_valid,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        HOLD,
        DRAIN,
        FIN
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] rd_addr;
    logic [LEN_W-1:0]  words_left;
    logic [1:0]        hold_cnt;
    logic [1:0]        phase_rem;
    logic              last_loaded;
    logic [1:0]        phases_m1;
    logic              issue_fire;
    logic              final_word;

    // Number of mux phases per word minus one, derived from the latched
    // bitwidth so it stays fixed for the whole run.
    always_comb begin
        phases_m1 = 2'd3;
        case (cfg_bitwidth)
            2'b00:   phases_m1 = 2'd0;
            2'b01:   phases_m1 = 2'd1;
            default: phases_m1 = 2'd3;
        endcase
    end

    // The read strobe follows pe_ready in the same cycle. A paused boundary
    // therefore resumes on the very cycle the PE array becomes ready again.
    assign issue_fire  = (state == ISSUE) && pe_ready;
    assign final_word  = (words_left == LEN_W'(1));
    assign buf_rd_en   = issue_fire;
    assign buf_rd_addr = rd_addr;

    // Main sequencer. The mux activity tracking (phase_rem and mux_clear) sits
    // beside the FSM. A read in cycle c makes the mux active in c+1..c+P.
    // out_valid and out_last trail that activity by one cycle. In the N=0
    // case FIN is entered with done still low, and FIN then spends one extra
    // cycle raising done. This gives busy one high cycle before the pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            rd_addr      <= '0;
            words_left   <= '0;
            hold_cnt     <= '0;
            phase_rem    <= '0;
            last_loaded  <= 1'b0;
            cfg_bitwidth <= 2'b00;
            mux_clear    <= 1'b1;
            out_valid    <= 1'b0;
            out_last     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            if (issue_fire) begin
                mux_clear   <= 1'b0;
                phase_rem   <= phases_m1;
                last_loaded <= final_word;
            end else if (phase_rem != 2'd0) begin
                phase_rem <= phase_rem - 2'd1;
            end else begin
                mux_clear <= 1'b1;
            end

            out_valid <= !mux_clear;
            out_last  <= !mux_clear && (phase_rem == 2'd0) && last_loaded;

            case (state)
                IDLE: begin
                    if (start) begin
                        rd_addr      <= base_addr;
                        words_left   <= num_words;
                        cfg_bitwidth <= weight_bitwidth;
                        busy         <= 1'b1;
                        state        <= (num_words == '0) ? FIN : ISSUE;
                    end
                end
                ISSUE: begin
                    if (pe_ready) begin
                        rd_addr    <= rd_addr + ADDR_W'(1);
                        words_left <= words_left - LEN_W'(1);
                        if (phases_m1 == 2'd0) begin
                            state <= final_word ? DRAIN : ISSUE;
                        end else begin
                            hold_cnt <= phases_m1 - 2'd1;
                            state    <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (hold_cnt == 2'd0) begin
                        state <= (words_left != '0) ? ISSUE : DRAIN;
                    end else begin
                        hold_cnt <= hold_cnt - 2'd1;
                    end
                end
                DRAIN: begin
                    if (out_last) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= FIN;
                    end
                end
                FIN: begin
                    if (!done) begin
                        done <= 1'b1;
                        busy <= 1'b0;
                    end else begin
                        done  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_input_buffer_sequencer.sv
// ---------------------------------------------------------------------------
// tb_input_buffer_sequencer
//
// Scenario tasks drive the sequencer. Each task pushes the read and
// output events it expects onto queues, built from the documented timing.
// A monitor forked from the main initial block pops those events at every
// falling edge and compares them. Cycle 0 of a scenario is the cycle in
// which start is driven high.
// ---------------------------------------------------------------------------
module tb_input_buffer_sequencer;

    typedef struct {
        int         cyc;
        logic [9:0] addr;
    } rd_t;

    typedef struct {
        int   cyc;
        logic last;
    } vl_t;

    logic       clk;
    logic       reset;
    logic       start;
    logic [9:0] base_addr;
    logic [9:0] num_words;
    logic [1:0] weight_bitwidth;
    logic       pe_ready;
    logic       buf_rd_en;
    logic [9:0] buf_rd_addr;
    logic [1:0] cfg_bitwidth;
    logic       mux_clear;
    logic       out_valid;
    logic       out_last;
    logic       busy;
    logic       done;

    int         checks;
    int         errors;
    int         cyc;
    bit         mon_en;
    bit         active_exp [0:63];
    int         exp_done;
    int         busy_end;
    int         done_cnt;
    int         done_cyc;
    int         rd_seen;
    int         vl_seen;
    logic [1:0] exp_bw;
    rd_t        rd_q [$];
    vl_t        vq [$];
    rd_t        mr;
    vl_t        mv;

    input_buffer_sequencer #(.ADDR_W(10), .LEN_W(10)) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .base_addr       (base_addr),
        .num_words       (num_words),
        .weight_bitwidth (weight_bitwidth),
        .pe_ready        (pe_ready),
        .buf_rd_en       (buf_rd_en),
        .buf_rd_addr     (buf_rd_addr),
        .cfg_bitwidth    (cfg_bitwidth),
        .mux_clear       (mux_clear),
        .out_valid       (out_valid),
        .out_last        (out_last),
        .busy            (busy),
        .done            (done)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Forget every expectation left over from the previous scenario.
    task automatic clear_expect();
        rd_q.delete();
        vq.delete();
        foreach (active_exp[i]) active_exp[i] = 1'b0;
        exp_done = -1;
        busy_end = 0;
        done_cnt = 0;
        done_cyc = -1;
        rd_seen  = 0;
        vl_seen  = 0;
    endtask

    // Reference timing model. Word i is read at 1 + i*P. A pause of pl
    // cycles that begins exactly on a boundary shifts every later event.
    // Each read makes the mux active for P cycles and produces P valid
    // outputs one cycle after each active cycle.
    task automatic build_expect(input logic [9:0] base, input int n, input int p,
                                input int ps, input int pl);
        int         t;
        int         shift;
        int         last_v;
        logic [9:0] a;
        shift  = 0;
        last_v = 0;
        if (n == 0) begin
            exp_done = 2;
            busy_end = 2;
        end else begin
            for (int i = 0; i < n; i++) begin
                t = 1 + i * p + shift;
                if (pl > 0 && t == ps) begin
                    shift += pl;
                    t     += pl;
                end
                a = base + 10'(i);
                rd_q.push_back('{t, a});
                for (int j = 0; j < p; j++) begin
                    if (t + 1 + j < 64) active_exp[t + 1 + j] = 1'b1;
                    vq.push_back('{t + 2 + j, logic'(i == n - 1 && j == p - 1)});
                end
                last_v = t + p + 1;
            end
            exp_done = last_v + 1;
            busy_end = exp_done;
        end
    endtask

    // Drive an accepted start in cycle 0 of a new scenario.
    task automatic kick(input logic [9:0] base, input logic [9:0] n, input logic [1:0] bw);
        @(posedge clk);
        #1;
        cyc             = 0;
        start           = 1'b1;
        base_addr       = base;
        num_words       = n;
        weight_bitwidth = bw;
        pe_ready        = 1'b1;
        exp_bw          = bw;
        mon_en          = 1'b1;
    endtask

    // Advance n cycles with start low. pe_ready is low in cycles ps..ps+pl-1.
    task automatic run_cycles(input int n, input int ps, input int pl);
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
            start    = 1'b0;
            pe_ready = !(pl > 0 && cyc >= ps && cyc < ps + pl);
        end
    endtask

    // Outputs while reset is held, before any run.
    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks += 8;
        if (buf_rd_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_rd_en actual=%b required=0", buf_rd_en); end
        if (buf_rd_addr !== 10'h000) begin errors++; $display("[TB] FAIL reset_rd_addr actual=%h required=000", buf_rd_addr); end
        if (cfg_bitwidth !== 2'b00) begin errors++; $display("[TB] FAIL reset_cfg actual=%b required=00", cfg_bitwidth); end
        if (mux_clear !== 1'b1) begin errors++; $display("[TB] FAIL reset_mux_clear actual=%b required=1", mux_clear); end
        if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid actual=%b required=0", out_valid); end
        if (out_last !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_last actual=%b required=0", out_last); end
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy actual=%b required=0", busy); end
        if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done actual=%b required=0", done); end
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // 8-bit mode: back-to-back reads, done in cycle 7.
    task automatic test_mode00();
        clear_expect();
        build_expect(10'h010, 4, 1, 0, 0);
        kick(10'h010, 10'd4, 2'b00);
        run_cycles(9, 0, 0);
        @(posedge clk);
        mon_en = 1'b0;
        checks += 4;
        if (done_cyc !== 7 || done_cnt !== 1) begin errors++; $display("[TB] FAIL m00_done actual=%0d/%0d required=7/1", done_cyc, done_cnt); end
        if (rd_seen !== 4) begin errors++; $display("[TB] FAIL m00_reads actual=%0d required=4", rd_seen); end
        if (vl_seen !== 4) begin errors++; $display("[TB] FAIL m00_valids actual=%0d required=4", vl_seen); end
        if (rd_q.size() != 0 || vq.size() != 0) begin errors++; $display("[TB] FAIL m00_pending actual=%0d/%0d required=0/0", rd_q.size(), vq.size()); end
    endtask

    // 4-bit mode: reads every second cycle, continuous valid 3..8.
    task automatic test_mode01();
        clear_expect();
        build_expect(10'h020, 3, 2, 0, 0);
        kick(10'h020, 10'd3, 2'b01);
        run_cycles(11, 0, 0);
        @(posedge clk);
        mon_en = 1'b0;
        checks += 3;
        if (done_cyc !== 9 || done_cnt !== 1) begin errors++; $display("[TB] FAIL m01_done actual=%0d/%0d required=9/1", done_cyc, done_cnt); end
        if (rd_seen !== 3 || vl_seen !== 6) begin errors++; $display("[TB] FAIL m01_counts actual=%0d/%0d required=3/6", rd_seen, vl_seen); end
        if (rd_q.size() != 0 || vq.size() != 0) begin errors++; $display("[TB] FAIL m01_pending actual=%0d/%0d required=0/0", rd_q.size(), vq.size()); end
    endtask

    // 2-bit mode with pe_ready low in cycles 5..7 at the second boundary.
    task automatic test_pause();
        clear_expect();
        build_expect(10'h030, 2, 4, 5, 3);
        kick(10'h030, 10'd2, 2'b10);
        run_cycles(16, 5, 3);
        @(posedge clk);
        mon_en = 1'b0;
        checks += 3;
        if (done_cyc !== 14 || done_cnt !== 1) begin errors++; $display("[TB] FAIL pause_done actual=%0d/%0d required=14/1", done_cyc, done_cnt); end
        if (rd_seen !== 2 || vl_seen !== 8) begin errors++; $display("[TB] FAIL pause_counts actual=%0d/%0d required=2/8", rd_seen, vl_seen); end
        if (rd_q.size() != 0 || vq.size() != 0) begin errors++; $display("[TB] FAIL pause_pending actual=%0d/%0d required=0/0", rd_q.size(), vq.size()); end
    endtask

    // Zero-length run: busy for one cycle, done in cycle 2, no reads.
    task automatic test_zero_words();
        clear_expect();
        build_expect(10'h0AA, 0, 1, 0, 0);
        kick(10'h0AA, 10'd0, 2'b01);
        run_cycles(4, 0, 0);
        @(posedge clk);
        mon_en = 1'b0;
        checks += 2;
        if (done_cyc !== 2 || done_cnt !== 1) begin errors++; $display("[TB] FAIL zero_done actual=%0d/%0d required=2/1", done_cyc, done_cnt); end
        if (rd_seen !== 0 || vl_seen !== 0) begin errors++; $display("[TB] FAIL zero_activity actual=%0d/%0d required=0/0", rd_seen, vl_seen); end
    endtask

    // A start in cycle 2 of a running job must not disturb it.
    task automatic test_ignore_start();
        clear_expect();
        build_expect(10'h100, 2, 1, 0, 0);
        kick(10'h100, 10'd2, 2'b00);
        run_cycles(1, 0, 0);
        @(posedge clk);
        #1;
        cyc++;
        start           = 1'b1;
        base_addr       = 10'h200;
        num_words       = 10'd5;
        weight_bitwidth = 2'b01;
        run_cycles(5, 0, 0);
        @(posedge clk);
        mon_en = 1'b0;
        checks += 2;
        if (done_cyc !== 5 || done_cnt !== 1) begin errors++; $display("[TB] FAIL ignore_done actual=%0d/%0d required=5/1", done_cyc, done_cnt); end
        if (rd_seen !== 2 || rd_q.size() != 0 || vq.size() != 0) begin errors++; $display("[TB] FAIL ignore_reads actual=%0d/%0d required=2/0", rd_seen, rd_q.size()); end
    endtask

    // Address wrap from 0x3FE through 0x000.
    task automatic test_wrap();
        clear_expect();
        build_expect(10'h3FE, 3, 1, 0, 0);
        kick(10'h3FE, 10'd3, 2'b00);
        run_cycles(8, 0, 0);
        @(posedge clk);
        mon_en = 1'b0;
        checks += 2;
        if (done_cyc !== 6 || done_cnt !== 1) begin errors++; $display("[TB] FAIL wrap_done actual=%0d/%0d required=6/1", done_cyc, done_cnt); end
        if (rd_seen !== 3 || rd_q.size() != 0 || vq.size() != 0) begin errors++; $display("[TB] FAIL wrap_reads actual=%0d/%0d required=3/0", rd_seen, rd_q.size()); end
    endtask

    // Reset held in cycle 8, the third phase of word 1 in 2-bit mode.
    task automatic test_reset_midrun();
        clear_expect();
        rd_q.push_back('{1, 10'h040});
        rd_q.push_back('{5, 10'h041});
        for (int k = 3; k <= 8; k++) vq.push_back('{k, 1'b0});
        for (int k = 2; k <= 8; k++) active_exp[k] = 1'b1;
        busy_end = 9;
        kick(10'h040, 10'd3, 2'b10);
        run_cycles(7, 0, 0);
        @(posedge clk);
        #1;
        cyc++;
        reset = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
        reset = 1'b0;
        @(negedge clk);
        checks += 3;
        if (buf_rd_en !== 1'b0 || buf_rd_addr !== 10'h000) begin errors++; $display("[TB] FAIL midrst_read actual=%b/%h required=0/000", buf_rd_en, buf_rd_addr); end
        if (cfg_bitwidth !== 2'b00 || mux_clear !== 1'b1) begin errors++; $display("[TB] FAIL midrst_mux actual=%b/%b required=00/1", cfg_bitwidth, mux_clear); end
        if (out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midrst_flags actual=%b%b%b%b required=0000", out_valid, out_last, busy, done);
        end
        run_cycles(2, 0, 0);
        @(posedge clk);
        mon_en = 1'b0;
        checks += 2;
        if (done_cnt !== 0) begin errors++; $display("[TB] FAIL midrst_done actual=%0d required=0", done_cnt); end
        if (rd_seen !== 2 || rd_q.size() != 0 || vq.size() != 0) begin errors++; $display("[TB] FAIL midrst_pending actual=%0d/%0d required=2/0", rd_seen, vq.size()); end
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        cyc             = 0;
        mon_en          = 1'b0;
        reset           = 1'b1;
        start           = 1'b0;
        base_addr       = '0;
        num_words       = '0;
        weight_bitwidth = 2'b00;
        pe_ready        = 1'b1;
        exp_bw          = 2'b00;
        clear_expect();

        // Scoreboard monitor: pop expectations as the DUT produces events.
        fork
            forever begin
                @(negedge clk);
                if (mon_en) begin
                    if (buf_rd_en === 1'b1) begin
                        rd_seen++;
                        checks++;
                        if (rd_q.size() == 0) begin
                            errors++;
                            $display("[TB] FAIL rd_unexpected actual cyc=%0d addr=%h required=no read", cyc, buf_rd_addr);
                        end else begin
                            mr = rd_q.pop_front();
                            if (mr.cyc !== cyc || mr.addr !== buf_rd_addr) begin
                                errors++;
                                $display("[TB] FAIL rd_seq actual cyc=%0d addr=%h required cyc=%0d addr=%h", cyc, buf_rd_addr, mr.cyc, mr.addr);
                            end
                        end
                    end
                    if (out_valid === 1'b1) begin
                        vl_seen++;
                        checks++;
                        if (vq.size() == 0) begin
                            errors++;
                            $display("[TB] FAIL valid_unexpected actual cyc=%0d required=no valid", cyc);
                        end else begin
                            mv = vq.pop_front();
                            if (mv.cyc !== cyc || mv.last !== out_last) begin
                                errors++;
                                $display("[TB] FAIL valid_seq actual cyc=%0d last=%b required cyc=%0d last=%b", cyc, out_last, mv.cyc, mv.last);
                            end
                        end
                    end
                    checks++;
                    if (out_last === 1'b1 && out_valid !== 1'b1) begin
                        errors++;
                        $display("[TB] FAIL last_alone actual cyc=%0d valid=%b required=1", cyc, out_valid);
                    end
                    if (cyc < 64) begin
                        checks++;
                        if (mux_clear !== (active_exp[cyc] ? 1'b0 : 1'b1)) begin
                            errors++;
                            $display("[TB] FAIL mux_clear actual cyc=%0d clr=%b required=%b", cyc, mux_clear, !active_exp[cyc]);
                        end
                    end
                    checks++;
                    if (busy !== ((cyc >= 1 && cyc < busy_end) ? 1'b1 : 1'b0)) begin
                        errors++;
                        $display("[TB] FAIL busy actual cyc=%0d busy=%b required=%b", cyc, busy, (cyc >= 1 && cyc < busy_end));
                    end
                    if (cyc >= 1 && cyc < busy_end) begin
                        checks++;
                        if (cfg_bitwidth !== exp_bw) begin
                            errors++;
                            $display("[TB] FAIL cfg_bitwidth actual cyc=%0d cfg=%b required=%b", cyc, cfg_bitwidth, exp_bw);
                        end
                    end
                    if (done === 1'b1) begin
                        done_cnt++;
                        done_cyc = cyc;
                    end
                end
            end
        join_none

        test_reset();
        test_mode00();
        test_mode01();
        test_pause();
        test_zero_words();
        test_ignore_start();
        test_wrap();
        test_reset_midrun();
        test_mode00();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
